// File: rtl/signed_mult_seq_ctrl_pkg.sv
// Shared definitions for the sequential signed multiplier controller.
// Holds FSM state encodings, default operand width and counter width.
package signed_mult_seq_ctrl_pkg;

   localparam int WIDTH_DEF = 10;
   localparam int CNT_W_DEF = $clog2(WIDTH_DEF + 1);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ABS  = 3'd1,
      ST_RUN  = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

endpackage

// File: rtl/signed_mult_seq_ctrl_step.sv
// Arithmetic building blocks: adder, two's-complement unit and the combinational
// shift-add step used once per multiplier iteration.
module mult_adder #(
   parameter int W = 20
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum
);
   assign sum = a + b;
endmodule

module mult_twos_comp #(
   parameter int W = 10
) (
   input  logic [W-1:0] x,
   input  logic         neg,
   output logic [W-1:0] y
);
   logic [W-1:0] inv;
   assign inv = ~x;
   // Negating zero wraps back to zero, so a zero product never turns nonzero.
   assign y = neg ? (inv + 1'b1) : x;
endmodule

module mult_shift_add_step #(
   parameter int WIDTH = 10,
   parameter int CNT_W = 4
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   ma,
   input  logic               mb0,
   input  logic [CNT_W-1:0]   cnt,
   output logic [2*WIDTH-1:0] acc_nxt
);
   logic [2*WIDTH-1:0] ma_ext;
   logic [2*WIDTH-1:0] addend;

   assign ma_ext = {{WIDTH{1'b0}}, ma};
   assign addend = mb0 ? (ma_ext << cnt) : '0;

   mult_adder #(.W(2*WIDTH)) u_add (
      .a   (acc),
      .b   (addend),
      .sum (acc_nxt)
   );
endmodule

// File: rtl/signed_mult_seq_ctrl.sv
// Sequencing controller for a signed WIDTH x WIDTH shift-add multiplier.
// Optional EARLY_TERM_EN: leave RUN as soon as no multiplier bits remain.
module signed_mult_seq_ctrl
   import signed_mult_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a_in,
   input  logic [WIDTH-1:0]     b_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   p_out,
   output logic                 busy
);

   localparam int PW    = 2 * WIDTH;
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t state, state_nxt;

   logic [WIDTH-1:0] a_reg, b_reg;
   logic [WIDTH-1:0] ma, mb;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic             sign;
   logic [PW-1:0]    acc, acc_nxt, p_fix, p_reg;
   logic [CNT_W-1:0] cnt;
   logic             mb_empty;
   logic             do_step;

   mult_twos_comp #(.W(WIDTH)) u_abs_a (
      .x   (a_reg),
      .neg (a_reg[WIDTH-1]),
      .y   (a_mag)
   );

   mult_twos_comp #(.W(WIDTH)) u_abs_b (
      .x   (b_reg),
      .neg (b_reg[WIDTH-1]),
      .y   (b_mag)
   );

   mult_shift_add_step #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_step (
      .acc     (acc),
      .ma      (ma),
      .mb0     (mb[0]),
      .cnt     (cnt),
      .acc_nxt (acc_nxt)
   );

   mult_twos_comp #(.W(PW)) u_neg_p (
      .x   (acc),
      .neg (sign),
      .y   (p_fix)
   );

   assign mb_empty = (mb == '0);

`ifdef EARLY_TERM_EN
   assign do_step = (state == ST_RUN) && !mb_empty;
`else
   assign do_step = (state == ST_RUN);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               state_nxt = ST_ABS;
            end
         end
         ST_ABS: begin
            state_nxt = ST_RUN;
         end
         ST_RUN: begin
`ifdef EARLY_TERM_EN
            if (mb_empty || (cnt == LAST_CNT)) begin
               state_nxt = ST_FIX;
            end
`else
            if (cnt == LAST_CNT) begin
               state_nxt = ST_FIX;
            end
`endif
         end
         ST_FIX: begin
            state_nxt = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg <= '0;
         b_reg <= '0;
         sign  <= 1'b0;
         ma    <= '0;
         mb    <= '0;
         acc   <= '0;
         cnt   <= '0;
         p_reg <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_reg <= a_in;
                  b_reg <= b_in;
                  sign  <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
               end
            end
            ST_ABS: begin
               ma  <= a_mag;
               mb  <= b_mag;
               acc <= '0;
               cnt <= '0;
            end
            ST_RUN: begin
               if (do_step) begin
                  acc <= acc_nxt;
                  mb  <= mb >> 1;
                  cnt <= cnt + 1'b1;
               end
            end
            ST_FIX: begin
               p_reg <= p_fix;
            end
            default: begin
            end
         endcase
      end
   end

   assign p_out = p_reg;

endmodule
